// File: rtl/approx_mult_err_monitor.sv
// approx_mult_err_monitor
// Scores an approximate unsigned WIDTH x WIDTH multiplier by streaming
// (x, y, z_approx) samples through a two-stage pipeline. It accumulates the
// sample count, the erroneous-sample count, the saturating sum of error
// distance and the maximum error distance.
// Optional feature: define ERR_BIAS_EN to add the signed bias_sum output.
// bias_sum is a symmetric-saturating sum of (z_approx - x*y).
module approx_mult_err_monitor #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned CNT_W = 17,
    parameter int unsigned ACC_W = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 clear,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic                 in_last,
    input  logic [WIDTH-1:0]     x,
    input  logic [WIDTH-1:0]     y,
    input  logic [2*WIDTH-1:0]   z_approx,
    output logic [CNT_W-1:0]     sample_cnt,
    output logic [CNT_W-1:0]     err_cnt,
    output logic [ACC_W-1:0]     sum_ed,
    output logic [2*WIDTH-1:0]   max_ed,
    output logic                 stats_valid
`ifdef ERR_BIAS_EN
    ,
    output logic signed [ACC_W:0] bias_sum
`endif
);

    localparam int unsigned PW    = 2 * WIDTH;
    // Wide enough to hold sum_ed + ED without overflow, even when ACC_W < PW
    localparam int unsigned SUM_W = ((ACC_W > PW) ? ACC_W : PW) + 1;
    localparam logic [SUM_W-1:0] SUM_CAP = {{(SUM_W-ACC_W){1'b0}}, {ACC_W{1'b1}}};

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

    state_t          state;
    state_t          state_next;
    logic            drain_cnt;
    logic            drain_cnt_next;
    logic            accept;

    logic            s1_valid;
    logic [PW-1:0]   s1_exact;
    logic [PW-1:0]   s1_z;
    logic [PW-1:0]   ed_c;

    logic            s2_valid;
    logic [PW-1:0]   s2_ed;

    logic [SUM_W-1:0] sum_ext;
    logic [ACC_W-1:0] sum_next;
    logic [CNT_W-1:0] cnt_next;
    logic [CNT_W-1:0] err_next;
    logic [PW-1:0]    max_next;

`ifdef ERR_BIAS_EN
    localparam int unsigned BW = (((ACC_W + 1) > (PW + 1)) ? (ACC_W + 1) : (PW + 1)) + 1;
    localparam logic signed [BW-1:0] BIAS_CAP   = {{(BW-ACC_W){1'b0}}, {ACC_W{1'b1}}};
    localparam logic signed [BW-1:0] BIAS_FLOOR = -BIAS_CAP;

    logic signed [PW:0]    diff_c;
    logic signed [PW:0]    s2_diff;
    logic signed [BW-1:0]  bias_ext;
    logic signed [ACC_W:0] bias_next;
`endif

    // Control FSM: state register
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            drain_cnt <= 1'b0;
        end else begin
            state     <= state_next;
            drain_cnt <= drain_cnt_next;
        end
    end

    // Control FSM: next state, handshake and status decode; clear overrides all states
    always_comb begin
        state_next     = state;
        drain_cnt_next = drain_cnt;
        in_ready       = 1'b0;
        stats_valid    = 1'b0;
        accept         = 1'b0;
        unique case (state)
            IDLE: ;
            RUN: begin
                in_ready = 1'b1;
                if (in_valid && in_last) begin
                    state_next     = DRAIN;
                    drain_cnt_next = 1'b0;
                end
            end
            DRAIN: begin
                if (drain_cnt) begin
                    state_next = DONE;
                end else begin
                    drain_cnt_next = 1'b1;
                end
            end
            DONE: stats_valid = 1'b1;
        endcase
        accept = in_ready && in_valid && !clear;
        if (clear) begin
            state_next     = RUN;
            drain_cnt_next = 1'b0;
        end
    end

    // Stage 1: register exact product and approximate product
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            s1_valid <= 1'b0;
        end else begin
            s1_valid <= accept;
        end
        if (accept) begin
            s1_exact <= PW'(x) * PW'(y);
            s1_z     <= z_approx;
        end
    end

    // Stage 2 arithmetic: unsigned error distance (and signed difference)
    always_comb begin
        if (s1_z >= s1_exact) begin
            ed_c = s1_z - s1_exact;
        end else begin
            ed_c = s1_exact - s1_z;
        end
`ifdef ERR_BIAS_EN
        diff_c = $signed({1'b0, s1_z}) - $signed({1'b0, s1_exact});
`endif
    end

    // Stage 2: register error distance
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            s2_valid <= 1'b0;
        end else begin
            s2_valid <= s1_valid;
        end
        if (s1_valid) begin
            s2_ed <= ed_c;
`ifdef ERR_BIAS_EN
            s2_diff <= diff_c;
`endif
        end
    end

    // Saturating next values of the statistics
    always_comb begin
        sum_ext  = SUM_W'(sum_ed) + SUM_W'(s2_ed);
        sum_next = (sum_ext > SUM_CAP) ? {ACC_W{1'b1}} : sum_ext[ACC_W-1:0];
        cnt_next = (sample_cnt == '1) ? sample_cnt : sample_cnt + CNT_W'(1);
        err_next = ((s2_ed != '0) && (err_cnt != '1)) ? err_cnt + CNT_W'(1) : err_cnt;
        max_next = (s2_ed > max_ed) ? s2_ed : max_ed;
`ifdef ERR_BIAS_EN
        bias_ext = BW'(bias_sum) + BW'(s2_diff);
        if (bias_ext > BIAS_CAP) begin
            bias_next = BIAS_CAP[ACC_W:0];
        end else if (bias_ext < BIAS_FLOOR) begin
            bias_next = BIAS_FLOOR[ACC_W:0];
        end else begin
            bias_next = bias_ext[ACC_W:0];
        end
`endif
    end

    // Statistics registers: zeroed by reset or clear, updated per stage-2 sample
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            sample_cnt <= '0;
            err_cnt    <= '0;
            sum_ed     <= '0;
            max_ed     <= '0;
`ifdef ERR_BIAS_EN
            bias_sum   <= '0;
`endif
        end else if (s2_valid) begin
            sample_cnt <= cnt_next;
            err_cnt    <= err_next;
            sum_ed     <= sum_next;
            max_ed     <= max_next;
`ifdef ERR_BIAS_EN
            bias_sum   <= bias_next;
`endif
        end
    end

endmodule

// File: tb/tb_approx_mult_err_monitor.sv
// Self-checking bench for approx_mult_err_monitor: single-sample vector table,
// hand-written multi-cycle sequences, randomized traffic against a reference
// model, and a narrow-accumulator instance for sum_ed saturation.
module tb_approx_mult_err_monitor;

    logic         clk = 1'b0;
    logic         rst;
    logic         clear;
    logic         in_valid;
    logic         in_ready;
    logic         in_last;
    logic [7:0]   x;
    logic [7:0]   y;
    logic [15:0]  z_approx;
    logic [16:0]  sample_cnt;
    logic [16:0]  err_cnt;
    logic [31:0]  sum_ed;
    logic [15:0]  max_ed;
    logic         stats_valid;
`ifdef ERR_BIAS_EN
    logic signed [32:0] bias_sum;
`endif

    logic         s_clear;
    logic         s_in_valid;
    logic         s_in_ready;
    logic         s_in_last;
    logic [7:0]   s_x;
    logic [7:0]   s_y;
    logic [15:0]  s_z;
    logic [16:0]  s_sample_cnt;
    logic [16:0]  s_err_cnt;
    logic [7:0]   s_sum_ed;
    logic [15:0]  s_max_ed;
    logic         s_stats_valid;
`ifdef ERR_BIAS_EN
    logic signed [8:0] s_bias_sum;
`endif

    always #5 clk = ~clk;

    approx_mult_err_monitor #(.WIDTH(8), .CNT_W(17), .ACC_W(32)) u_dut (
        .clk(clk), .rst(rst), .clear(clear), .in_valid(in_valid),
        .in_ready(in_ready), .in_last(in_last), .x(x), .y(y),
        .z_approx(z_approx), .sample_cnt(sample_cnt), .err_cnt(err_cnt),
        .sum_ed(sum_ed), .max_ed(max_ed), .stats_valid(stats_valid)
`ifdef ERR_BIAS_EN
        , .bias_sum(bias_sum)
`endif
    );

    approx_mult_err_monitor #(.WIDTH(8), .CNT_W(17), .ACC_W(8)) u_sat (
        .clk(clk), .rst(rst), .clear(s_clear), .in_valid(s_in_valid),
        .in_ready(s_in_ready), .in_last(s_in_last), .x(s_x), .y(s_y),
        .z_approx(s_z), .sample_cnt(s_sample_cnt), .err_cnt(s_err_cnt),
        .sum_ed(s_sum_ed), .max_ed(s_max_ed), .stats_valid(s_stats_valid)
`ifdef ERR_BIAS_EN
        , .bias_sum(s_bias_sum)
`endif
    );

    int n_checks = 0;
    int n_errors = 0;

    function automatic void check(string name, longint act, longint exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
        end
    endfunction

    // ---------------- reference model ----------------
    typedef enum {M_IDLE, M_RUN, M_DRAIN, M_DONE} mmode_t;
    typedef struct {longint due; longint diff;} pend_t;

    localparam longint CNT_MAX  = (longint'(1) << 17) - 1;
    localparam longint SUM_MAX  = (longint'(1) << 32) - 1;
    localparam longint BIAS_MAX = (longint'(1) << 32) - 1;

    mmode_t  m_mode;
    int      m_drain;
    longint  m_cnt, m_err, m_sum, m_max, m_bias, edge_n;
    pend_t   pend[$];

    function automatic void model_zero();
        m_cnt = 0; m_err = 0; m_sum = 0; m_max = 0; m_bias = 0;
        pend.delete();
    endfunction

    function automatic void compare_all();
        check("in_ready",    longint'(in_ready),    longint'(m_mode == M_RUN));
        check("stats_valid", longint'(stats_valid), longint'(m_mode == M_DONE));
        check("sample_cnt",  longint'(sample_cnt),  m_cnt);
        check("err_cnt",     longint'(err_cnt),     m_err);
        check("sum_ed",      longint'(sum_ed),      m_sum);
        check("max_ed",      longint'(max_ed),      m_max);
`ifdef ERR_BIAS_EN
        check("bias_sum",    longint'(bias_sum),    m_bias);
`endif
    endfunction

    // Advance one clock edge, update the model from pre-edge inputs, then compare
    task automatic tick();
        bit     hs;
        longint d;
        longint ed;
        pend_t  p;
        hs = (m_mode == M_RUN) && in_valid && !clear && !rst;
        d  = longint'(z_approx) - longint'(x) * longint'(y);
        @(posedge clk);
        edge_n++;
        if (rst) begin
            model_zero();
            m_mode = M_IDLE;
        end else if (clear) begin
            model_zero();
            m_mode = M_RUN;
        end else begin
            while (pend.size() > 0 && pend[0].due == edge_n) begin
                p  = pend.pop_front();
                ed = (p.diff < 0) ? -p.diff : p.diff;
                m_cnt  = (m_cnt + 1 > CNT_MAX) ? CNT_MAX : m_cnt + 1;
                if (ed != 0) m_err = (m_err + 1 > CNT_MAX) ? CNT_MAX : m_err + 1;
                m_sum  = (m_sum + ed > SUM_MAX) ? SUM_MAX : m_sum + ed;
                if (ed > m_max) m_max = ed;
                m_bias = m_bias + p.diff;
                if (m_bias > BIAS_MAX) m_bias = BIAS_MAX;
                if (m_bias < -BIAS_MAX) m_bias = -BIAS_MAX;
            end
            if (hs) begin
                pend.push_back('{edge_n + 2, d});
                if (in_last) begin
                    m_mode  = M_DRAIN;
                    m_drain = 2;
                end
            end else if (m_mode == M_DRAIN) begin
                m_drain--;
                if (m_drain == 0) m_mode = M_DONE;
            end
        end
        #1;
        compare_all();
    endtask

    task automatic drive(input logic v, input logic [7:0] xa, input logic [7:0] ya,
                         input logic [15:0] za, input logic la);
        in_valid = v; x = xa; y = ya; z_approx = za; in_last = la;
    endtask

    task automatic do_clear();
        clear = 1'b1;
        tick();
        clear = 1'b0;
    endtask

    task automatic check_stats(string tag, longint c, longint e, longint s, longint m, longint sv);
        check({tag, ".sample_cnt"},  longint'(sample_cnt),  c);
        check({tag, ".err_cnt"},     longint'(err_cnt),     e);
        check({tag, ".sum_ed"},      longint'(sum_ed),      s);
        check({tag, ".max_ed"},      longint'(max_ed),      m);
        check({tag, ".stats_valid"}, longint'(stats_valid), sv);
    endtask

    typedef struct {
        logic [7:0]  x;
        logic [7:0]  y;
        logic [15:0] z;
        longint      exp_err;
        longint      exp_ed;
    } vec_t;

    vec_t vecs[10];
    int   bp_exp[6];

    initial begin
        vecs[0] = '{8'd3,   8'd5,   16'd15,    0, 0};
        vecs[1] = '{8'd255, 8'd255, 16'd65025, 0, 0};
        vecs[2] = '{8'd0,   8'd200, 16'd0,     0, 0};
        vecs[3] = '{8'd255, 8'd255, 16'd65000, 1, 25};
        vecs[4] = '{8'd16,  8'd16,  16'd300,   1, 44};
        vecs[5] = '{8'd0,   8'd0,   16'd65535, 1, 65535};
        vecs[6] = '{8'd255, 8'd255, 16'd0,     1, 65025};
        vecs[7] = '{8'd10,  8'd10,  16'd99,    1, 1};
        vecs[8] = '{8'd128, 8'd2,   16'd255,   1, 1};
        vecs[9] = '{8'd200, 8'd100, 16'd20000, 0, 0};
        bp_exp  = '{0, 0, 1, 2, 3, 4};

        rst = 1'b1; clear = 1'b0;
        drive(1'b0, 8'd0, 8'd0, 16'd0, 1'b0);
        s_clear = 1'b0; s_in_valid = 1'b0; s_in_last = 1'b0;
        s_x = 8'd0; s_y = 8'd0; s_z = 16'd0;
        model_zero(); m_mode = M_IDLE; m_drain = 0; edge_n = 0;

        // Reset state
        tick(); tick();
        rst = 1'b0;
        check("reset.in_ready", longint'(in_ready), 0);
        check_stats("reset", 0, 0, 0, 0, 0);

        // in_valid pulse while IDLE is ignored
        drive(1'b1, 8'd7, 8'd7, 16'd49, 1'b0);
        tick();
        drive(1'b0, 8'd0, 8'd0, 16'd0, 1'b0);
        tick(); tick();
        check("idle.in_ready", longint'(in_ready), 0);
        check("idle.sample_cnt", longint'(sample_cnt), 0);

        // Exact samples; clear arrives with in_valid=1 and must not accept
        drive(1'b1, 8'd3, 8'd5, 16'd15, 1'b0);
        do_clear();
        tick();
        drive(1'b1, 8'd255, 8'd255, 16'd65025, 1'b0); tick();
        drive(1'b1, 8'd0, 8'd200, 16'd0, 1'b1);       tick();
        drive(1'b0, 8'd0, 8'd0, 16'd0, 1'b0);
        tick();
        check("exact.stats_valid_early", longint'(stats_valid), 0);
        tick();
        check_stats("exact", 3, 0, 0, 0, 1);

        // Mixed errors
        do_clear();
        drive(1'b1, 8'd255, 8'd255, 16'd65000, 1'b0); tick();
        drive(1'b1, 8'd16, 8'd16, 16'd300, 1'b1);     tick();
        drive(1'b0, 8'd0, 8'd0, 16'd0, 1'b0);
        tick(); tick();
        check_stats("mixed", 2, 2, 69, 44, 1);
`ifdef ERR_BIAS_EN
        check("mixed.bias_sum", longint'(bias_sum), 19);
`endif

        // Latency: sample_cnt trails the handshakes by two cycles
        do_clear();
        drive(1'b1, 8'd1, 8'd1, 16'd1, 1'b0);
        for (int i = 0; i < 6; i++) begin
            if (i == 4) drive(1'b0, 8'd0, 8'd0, 16'd0, 1'b0);
            tick();
            check("latency.sample_cnt", longint'(sample_cnt), bp_exp[i]);
        end

        // Clear colliding with the 6th handshake
        do_clear();
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, 8'(i + 2), 8'd9, 16'd1, 1'b0);
            tick();
        end
        drive(1'b1, 8'd50, 8'd50, 16'd0, 1'b0);
        clear = 1'b1;
        tick();
        clear = 1'b0;
        drive(1'b0, 8'd0, 8'd0, 16'd0, 1'b0);
        check_stats("collide", 0, 0, 0, 0, 0);
        tick(); tick(); tick();
        check_stats("collide_after", 0, 0, 0, 0, 0);

        // Single-sample table
        for (int i = 0; i < 10; i++) begin
            do_clear();
            drive(1'b1, vecs[i].x, vecs[i].y, vecs[i].z, 1'b1);
            tick();
            drive(1'b0, 8'd0, 8'd0, 16'd0, 1'b0);
            tick(); tick();
            check_stats($sformatf("vec%0d", i), 1, vecs[i].exp_err,
                        vecs[i].exp_ed, vecs[i].exp_ed, 1);
        end

        // Mid-run reset with samples in flight
        do_clear();
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 8'd20, 8'd20, 16'd7, 1'b0);
            tick();
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        drive(1'b0, 8'd0, 8'd0, 16'd0, 1'b0);
        check("midreset.in_ready", longint'(in_ready), 0);
        check_stats("midreset", 0, 0, 0, 0, 0);
        do_clear();
        drive(1'b1, 8'd4, 8'd4, 16'd20, 1'b1);
        tick();
        drive(1'b0, 8'd0, 8'd0, 16'd0, 1'b0);
        tick(); tick();
        check_stats("restart", 1, 1, 4, 4, 1);

        // Randomized traffic against the model
        do_clear();
        for (int i = 0; i < 600; i++) begin
            logic [7:0]  rx;
            logic [7:0]  ry;
            int          ex;
            logic [15:0] rz;
            rx = 8'($urandom);
            ry = 8'($urandom);
            ex = int'(rx) * int'(ry);
            case ($urandom_range(0, 3))
                0: rz = 16'(ex);
                1: rz = 16'(ex + int'($urandom_range(1, 300)));
                2: rz = 16'($urandom);
                default: rz = 16'(ex - int'($urandom_range(1, 300)));
            endcase
            drive($urandom_range(0, 3) != 0, rx, ry, rz, $urandom_range(0, 49) == 0);
            clear = ($urandom_range(0, 39) == 0);
            rst   = ($urandom_range(0, 199) == 0);
            tick();
        end
        clear = 1'b0; rst = 1'b0;
        do_clear();
        drive(1'b1, 8'd100, 8'd3, 16'd310, 1'b1);
        tick();
        drive(1'b0, 8'd0, 8'd0, 16'd0, 1'b0);
        tick(); tick(); tick();

        // Saturation on the ACC_W=8 instance: two samples with ED=200
        s_clear = 1'b1;
        @(posedge clk); #1;
        s_clear = 1'b0;
        s_in_valid = 1'b1; s_x = 8'd0; s_y = 8'd0; s_z = 16'd200;
        @(posedge clk); #1;
        s_in_last = 1'b1;
        @(posedge clk); #1;
        s_in_valid = 1'b0; s_in_last = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        check("sat.sum_ed",      longint'(s_sum_ed),      255);
        check("sat.max_ed",      longint'(s_max_ed),      200);
        check("sat.err_cnt",     longint'(s_err_cnt),     2);
        check("sat.sample_cnt",  longint'(s_sample_cnt),  2);
        check("sat.stats_valid", longint'(s_stats_valid), 1);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
